// File: rtl/filt_pkg.sv
// Shared sizing helpers and output-stage constants for the parametrised filter MAC engine.
package filt_pkg;

    function automatic int unsigned taps(input int unsigned n);
        return n * n;
    endfunction

    function automatic int unsigned clog2_ceil(input int unsigned x);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < x) r = r + 1;
        return r;
    endfunction

    // Address width that never collapses to zero bits for a single-tap kernel.
    function automatic int unsigned clog2_min1(input int unsigned x);
        return (x <= 1) ? 1 : clog2_ceil(x);
    endfunction

    function automatic int unsigned levels(input int unsigned t);
        return clog2_ceil(t);
    endfunction

    function automatic int unsigned level_count(input int unsigned t, input int unsigned l);
        int unsigned c;
        c = t;
        for (int unsigned i = 0; i < l; i++) c = (c + 1) / 2;
        return c;
    endfunction

    function automatic int round_term(input int unsigned shift);
        return (shift == 0) ? 0 : (1 << (shift - 1));
    endfunction

    function automatic int sat_max(input int unsigned pix_bit);
        return (1 << pix_bit) - 1;
    endfunction

    function automatic int sat_min(input int unsigned pix_bit);
        return -(1 << pix_bit);
    endfunction

endpackage

// File: rtl/filt_adder_tree.sv
// Pipelined binary reduction of T signed products; one register per level, odd
// last elements ride a delay register so every path has the same depth.
module filt_adder_tree
    import filt_pkg::*;
#(
    parameter int unsigned T      = 49,
    parameter int unsigned PROD_W = 25,
    parameter int unsigned SUM_W  = PROD_W + levels(T)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce,
    input  logic [T*PROD_W-1:0]     prod,
    output logic signed [SUM_W-1:0] sum
);

    localparam int unsigned LV = levels(T);

    for (genvar l = 0; l <= LV; l++) begin : lev
        localparam int unsigned CNT = level_count(T, l);
        logic signed [SUM_W-1:0] s [CNT];

        if (l == 0) begin : leaf
            for (genvar i = 0; i < CNT; i++) begin : ext
                assign s[i] = SUM_W'($signed(prod[i*PROD_W +: PROD_W]));
            end
        end else begin : node
            localparam int unsigned PREV = level_count(T, l - 1);
            for (genvar i = 0; i < CNT; i++) begin : elem
                if (2 * i + 1 < PREV) begin : pair
                    always_ff @(posedge clk) begin
                        if (reset)   s[i] <= '0;
                        else if (ce) s[i] <= lev[l-1].s[2*i] + lev[l-1].s[2*i+1];
                    end
                end else begin : pass
                    always_ff @(posedge clk) begin
                        if (reset)   s[i] <= '0;
                        else if (ce) s[i] <= lev[l-1].s[2*i];
                    end
                end
            end
        end
    end

    assign sum = lev[LV].s[0];

endmodule

// File: rtl/filter_mac_tree_param.sv
// N x N spatial-filter MAC: double-buffered coefficients, pipelined multiply,
// adder tree, round/shift/saturate. Define FILT_ABS_OUT_EN for magnitude output.
module filter_mac_tree_param
    import filt_pkg::*;
#(
    parameter int unsigned PIX_BIT     = 8,
    parameter int unsigned MASK_WIDTH  = 7,
    parameter int unsigned COEF_BIT    = 16,
    parameter int unsigned SHIFT       = 14,
    parameter int unsigned MULT_STAGES = 2
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      ce,
    input  logic                                      in_valid,
    input  logic [PIX_BIT*taps(MASK_WIDTH)-1:0]       p,
    input  logic                                      coef_wr_en,
    input  logic [clog2_min1(taps(MASK_WIDTH))-1:0]   coef_wr_addr,
    input  logic [COEF_BIT-1:0]                       coef_wr_data,
    input  logic                                      coef_swap,
    output logic                                      out_valid,
    output logic [PIX_BIT:0]                          q
);

    localparam int unsigned T      = taps(MASK_WIDTH);
    localparam int unsigned PROD_W = PIX_BIT + COEF_BIT + 1;
    localparam int unsigned LV     = levels(T);
    localparam int unsigned SUM_W  = PROD_W + LV;
    localparam int unsigned L      = MULT_STAGES + LV + 1;

    localparam logic signed [SUM_W:0] RND    = (SUM_W+1)'(round_term(SHIFT));
    localparam logic signed [SUM_W:0] SAT_HI = (SUM_W+1)'(sat_max(PIX_BIT));
`ifndef FILT_ABS_OUT_EN
    localparam logic signed [SUM_W:0] SAT_LO = (SUM_W+1)'(sat_min(PIX_BIT));
`endif

    logic signed [COEF_BIT-1:0] shadow [T];
    logic signed [COEF_BIT-1:0] active [T];

    // Swap copies the pre-edge shadow, so a same-cycle write only lands in shadow.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < T; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            if (coef_wr_en && (32'(coef_wr_addr) < T))
                shadow[coef_wr_addr] <= coef_wr_data;
            if (coef_swap)
                for (int unsigned k = 0; k < T; k++) active[k] <= shadow[k];
        end
    end

    logic signed [PROD_W-1:0] mult [MULT_STAGES][T];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned s = 0; s < MULT_STAGES; s++)
                for (int unsigned k = 0; k < T; k++) mult[s][k] <= '0;
        end else if (ce) begin
            for (int unsigned k = 0; k < T; k++)
                mult[0][k] <= PROD_W'($signed({1'b0, p[PIX_BIT*k +: PIX_BIT]}))
                            * PROD_W'(active[k]);
            for (int unsigned s = 1; s < MULT_STAGES; s++)
                for (int unsigned k = 0; k < T; k++) mult[s][k] <= mult[s-1][k];
        end
    end

    logic [T*PROD_W-1:0] prod_bus;

    always_comb begin
        prod_bus = '0;
        for (int unsigned k = 0; k < T; k++)
            prod_bus[k*PROD_W +: PROD_W] = mult[MULT_STAGES-1][k];
    end

    logic signed [SUM_W-1:0] sum;

    filt_adder_tree #(
        .T      (T),
        .PROD_W (PROD_W),
        .SUM_W  (SUM_W)
    ) u_tree (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .prod  (prod_bus),
        .sum   (sum)
    );

    logic signed [SUM_W:0] rnd;
    logic signed [SUM_W:0] r;
    logic [PIX_BIT:0]      q_next;
`ifdef FILT_ABS_OUT_EN
    logic signed [SUM_W:0] mag;
`endif

    always_comb begin
        rnd = (SUM_W+1)'(sum) + RND;
        r   = rnd >>> SHIFT;
`ifdef FILT_ABS_OUT_EN
        mag    = (r < 0) ? -r : r;
        q_next = (mag > SAT_HI) ? SAT_HI[PIX_BIT:0] : mag[PIX_BIT:0];
`else
        if (r > SAT_HI)      q_next = SAT_HI[PIX_BIT:0];
        else if (r < SAT_LO) q_next = SAT_LO[PIX_BIT:0];
        else                 q_next = r[PIX_BIT:0];
`endif
    end

    logic [L-1:0] vpipe;

    always_ff @(posedge clk) begin
        if (reset) begin
            vpipe <= '0;
            q     <= '0;
        end else if (ce) begin
            vpipe <= {vpipe[L-2:0], in_valid};
            q     <= q_next;
        end
    end

    assign out_valid = vpipe[L-1];

endmodule

// File: tb/tb_filter_mac_tree_param.sv
// Directed bench for filter_mac_tree_param: 7x7 default plus 3x3 and 5x5 builds.
module tb_filter_mac_tree_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, ce;
    logic         in_valid, coef_wr_en, coef_swap, out_valid;
    logic [391:0] p;
    logic [5:0]   coef_wr_addr;
    logic [15:0]  coef_wr_data;
    logic [8:0]   q;

    filter_mac_tree_param #(.PIX_BIT(8), .MASK_WIDTH(7), .COEF_BIT(16), .SHIFT(14), .MULT_STAGES(2)) dut (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .p(p),
        .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
        .coef_swap(coef_swap), .out_valid(out_valid), .q(q));

    logic        b_in_valid, b_wr_en, b_swap, b_out_valid;
    logic [71:0] b_p;
    logic [3:0]  b_addr;
    logic [15:0] b_data;
    logic [8:0]  b_q;

    filter_mac_tree_param #(.PIX_BIT(8), .MASK_WIDTH(3), .COEF_BIT(16), .SHIFT(14), .MULT_STAGES(2)) dut3 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(b_in_valid), .p(b_p),
        .coef_wr_en(b_wr_en), .coef_wr_addr(b_addr), .coef_wr_data(b_data),
        .coef_swap(b_swap), .out_valid(b_out_valid), .q(b_q));

    logic         c_in_valid, c_wr_en, c_swap, c_out_valid;
    logic [199:0] c_p;
    logic [4:0]   c_addr;
    logic [15:0]  c_data;
    logic [8:0]   c_q;

    filter_mac_tree_param #(.PIX_BIT(8), .MASK_WIDTH(5), .COEF_BIT(16), .SHIFT(14), .MULT_STAGES(2)) dut5 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(c_in_valid), .p(c_p),
        .coef_wr_en(c_wr_en), .coef_wr_addr(c_addr), .coef_wr_data(c_data),
        .coef_swap(c_swap), .out_valid(c_out_valid), .q(c_q));

    int n_tests = 0;
    int n_fail  = 0;
    int vcount  = 0;
    int exp_pipe [$];

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Hand-computed values assume signed output; magnitude mode folds them.
    function automatic int absx(input int v);
`ifdef FILT_ABS_OUT_EN
        if (v < 0) v = -v;
        if (v > 255) v = 255;
`endif
        return v;
    endfunction

    function automatic logic [391:0] px_tap(input int k, input int v);
        logic [391:0] r;
        r = '0;
        r[k*8 +: 8] = 8'(v);
        return r;
    endfunction

    function automatic logic [391:0] px_all(input int v);
        logic [391:0] r;
        for (int i = 0; i < 49; i++) r[i*8 +: 8] = 8'(v);
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One cycle of the 7x7 DUT; the queue holds the expected result per enabled edge.
    task automatic step(input logic c, input logic iv, input logic [391:0] pv,
                        input int expq, input string tag);
        int cur;
        ce = c; in_valid = iv; p = pv;
        tick();
        if (c) begin
            exp_pipe.push_back(iv ? expq : -1000);
            if (exp_pipe.size() > 9) void'(exp_pipe.pop_front());
        end
        cur = (exp_pipe.size() == 9) ? exp_pipe[0] : -1000;
        if (out_valid) vcount++;
        check({tag, "_valid"}, int'(out_valid), int'(cur != -1000));
        if (cur != -1000) check({tag, "_q"}, int'($signed(q)), cur);
        in_valid = 1'b0;
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 0, "flush");
    endtask

    task automatic wr(input int addr, input int data);
        coef_wr_en = 1'b1; coef_wr_addr = 6'(addr); coef_wr_data = 16'(data);
        step(1'b1, 1'b0, '0, 0, "wr");
        coef_wr_en = 1'b0;
    endtask

    task automatic swap_pulse;
        coef_swap = 1'b1;
        step(1'b1, 1'b0, '0, 0, "swap");
        coef_swap = 1'b0;
    endtask

    task automatic load_centre(input int v);
        for (int i = 0; i < 49; i++) wr(i, (i == 24) ? v : 0);
        swap_pulse();
    endtask

    task automatic load_all(input int v);
        for (int i = 0; i < 49; i++) wr(i, v);
        swap_pulse();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, v0;
        reset = 1'b1; ce = 1'b1; in_valid = 1'b0; p = '0;
        coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0; coef_swap = 1'b0;
        b_in_valid = 1'b0; b_wr_en = 1'b0; b_swap = 1'b0; b_p = '0; b_addr = '0; b_data = '0;
        c_in_valid = 1'b0; c_wr_en = 1'b0; c_swap = 1'b0; c_p = '0; c_addr = '0; c_data = '0;
        repeat (3) tick();
        check("rst_valid", int'(out_valid), 0);
        check("rst_q", int'(q), 0);
        reset = 1'b0;

        // Identity kernel and latency
        load_centre(16384);
        step(1'b1, 1'b1, px_tap(24, 200), 200, "ident");
        n = 1;
        while (!out_valid && n < 20) begin
            step(1'b1, 1'b0, '0, 0, "ident");
            n++;
        end
        check("ident_latency", n, 9);
        flush(3);

        v0 = vcount;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, px_tap(24, 10 + i*7), 10 + i*7, "b2b");
        flush(10);
        check("b2b_count", vcount - v0, 20);

        // Round half up: 3*0.5 -> 2, 2*0.5 -> 1
        load_centre(8192);
        step(1'b1, 1'b1, px_tap(24, 3), 2, "round3");
        step(1'b1, 1'b1, px_tap(24, 2), 1, "round2");
        flush(10);

        load_all(32767);
        step(1'b1, 1'b1, px_all(255), absx(255), "sat_pos");
        flush(10);
        load_all(-32768);
        step(1'b1, 1'b1, px_all(255), absx(-256), "sat_neg");
        flush(10);

        // Kernel write during stream, swap in cycle 6: windows 0..6 old, 7.. new
        load_centre(16384);
        for (int i = 0; i < 12; i++) begin
            if (i == 3) begin
                coef_wr_en = 1'b1; coef_wr_addr = 6'd24; coef_wr_data = 16'd8192;
            end
            if (i == 6) coef_swap = 1'b1;
            step(1'b1, 1'b1, px_tap(24, 100), (i <= 6) ? 100 : 50, "swap_t");
            coef_wr_en = 1'b0; coef_swap = 1'b0;
        end
        flush(10);

        wr(0, 16384);
        coef_wr_en = 1'b1; coef_wr_addr = 6'd0; coef_wr_data = 16'd0; coef_swap = 1'b1;
        step(1'b1, 1'b0, '0, 0, "wrswap");
        coef_wr_en = 1'b0; coef_swap = 1'b0;
        step(1'b1, 1'b1, px_tap(0, 40), 40, "wrswap_old");
        flush(9);
        swap_pulse();
        step(1'b1, 1'b1, px_tap(0, 40), 0, "wrswap_new");
        flush(9);

        // Stall with outputs already emerging; window offered during stall is dropped
        load_centre(16384);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, px_tap(24, 20 + i), 20 + i, "stall_in");
        flush(2);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, px_tap(24, 99), 99, "stall");
        flush(10);

        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, px_tap(24, 30 + i), 30 + i, "pre_rst");
        reset = 1'b1; ce = 1'b1; in_valid = 1'b0;
        tick();
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_q", int'(q), 0);
        tick();
        reset = 1'b0;
        exp_pipe.delete();
        flush(10);
        step(1'b1, 1'b1, px_all(255), 0, "post_rst");
        flush(10);

        // 3x3: even taps 1.0, odd taps -0.5, pixels 10..90 -> 150
        for (int k = 0; k < 9; k++) begin
            b_wr_en = 1'b1; b_addr = 4'(k); b_data = (k % 2 == 0) ? 16'd16384 : 16'hE000;
            tick();
        end
        b_wr_en = 1'b0; b_swap = 1'b1; tick(); b_swap = 1'b0;
        for (int k = 0; k < 9; k++) b_p[k*8 +: 8] = 8'(10 * (k + 1));
        b_in_valid = 1'b1; tick(); b_in_valid = 1'b0;
        n = 1;
        while (!b_out_valid && n < 20) begin tick(); n++; end
        check("m3_latency", n, 7);
        check("m3_q", int'($signed(b_q)), 150);
        for (int k = 0; k < 9; k++) b_p[k*8 +: 8] = (k % 2 == 0) ? 8'd0 : 8'd100;
        b_in_valid = 1'b1; tick(); b_in_valid = 1'b0;
        n = 1;
        while (!b_out_valid && n < 20) begin tick(); n++; end
        check("m3_neg_q", int'($signed(b_q)), absx(-200));

        // 5x5: tap 24 rides the odd pass-through path
        c_wr_en = 1'b1; c_addr = 5'd24; c_data = 16'd16384; tick(); c_wr_en = 1'b0;
        c_swap = 1'b1; tick(); c_swap = 1'b0;
        for (int k = 0; k < 25; k++) c_p[k*8 +: 8] = 8'd9;
        c_p[24*8 +: 8] = 8'd77;
        c_in_valid = 1'b1; tick(); c_in_valid = 1'b0;
        n = 1;
        while (!c_out_valid && n < 20) begin tick(); n++; end
        check("m5_latency", n, 8);
        check("m5_q", int'($signed(c_q)), 77);
        c_wr_en = 1'b1; c_addr = 5'd0; c_data = 16'hC000; tick(); c_wr_en = 1'b0;
        c_swap = 1'b1; tick(); c_swap = 1'b0;
        c_p = '0; c_p[7:0] = 8'd255; c_p[24*8 +: 8] = 8'd55;
        c_in_valid = 1'b1; tick(); c_in_valid = 1'b0;
        n = 1;
        while (!c_out_valid && n < 20) begin tick(); n++; end
        check("m5_neg_q", int'($signed(c_q)), absx(-200));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
